mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/mmio_uart_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: definitions shared by the MMIO UART transmitter and its bench.
//   - word offsets of the four registers (i_addr[3:2])
//   - STATUS / CTRL bit positions
//   - transmitter FSM state enum
//   - eff_div(): maps a programmed divisor of 0 to 1
package mmio_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A divisor of 0 would never finish a bit, so it is run as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, no write-to-read bypass.
//   i_clk, rst (sync, active-low)
//   push/wdata : enqueue; accepted when not full, or when full and a pop
//                is accepted in the same cycle (count unchanged)
//   pop/rdata  : rdata is always the head entry; pop is ignored when empty
//   full, empty, count (0..DEPTH)
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, the slot under wr_ptr is the head being popped this edge,
    // so overwriting it is safe.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge i_clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO.
//   i_clk, rst        : clock, synchronous active-low reset
//   i_we, i_re        : bus write / read strobes
//   i_addr, i_wdata   : byte address, write data
//   o_rdata           : combinational read data (0 on miss or no read)
//   o_tx              : serial line, idle high
//   o_irq             : registered level irq = irq_en & empty & ~busy
// Register map (word offset i_addr[3:2]): DATA, STATUS, DIV, CTRL.
//
// Bus handshake: a request is the single-cycle i_we / i_re strobe with
// i_addr. There is no ready: a hitting write always commits at the edge
// where i_we is high, and a read returns in the same cycle.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_4000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd434
) (
    input  logic        i_clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // bus decode
    logic       hit;
    logic       wr_hit;
    logic       rd_hit;
    logic [1:0] off;

    assign hit    = (i_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_hit = i_we && hit;
    assign rd_hit = i_re && hit;
    assign off    = i_addr[3:2];

    // registers
    logic [15:0] div_reg;
    logic        tx_en;
    logic        irq_en;
    logic        overflow;
    logic        irq_q;

    // FIFO
    logic          push_req;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign push_req = wr_hit && (off == OFF_DATA);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk (i_clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (i_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // transmitter FSM
    tx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [15:0] div_lat, div_lat_n;
    logic        last_tick;
    logic        busy;

    assign busy      = (state != ST_IDLE);
    assign last_tick = (cnt == div_lat - 16'd1);

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            div_lat <= 16'd1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            div_lat <= div_lat_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        div_lat_n = div_lat;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    pop       = 1'b1;
                    shreg_n   = fifo_rdata;
                    div_lat_n = eff_div(div_reg);
                    cnt_n     = '0;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (last_tick) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (last_tick) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = shreg >> 1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (last_tick) begin
                    cnt_n = '0;
                    // back-to-back frames: reload straight into START
                    if (tx_en && !fifo_empty) begin
                        pop       = 1'b1;
                        shreg_n   = fifo_rdata;
                        div_lat_n = eff_div(div_reg);
                        state_n   = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            ST_START: o_tx = 1'b0;
            ST_DATA:  o_tx = shreg[0];
            default:  o_tx = 1'b1;
        endcase
    end

    // register writes and irq
    always_ff @(posedge i_clk) begin
        if (!rst) begin
            div_reg  <= DIV_RST;
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= irq_en && fifo_empty && !busy;
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (wr_hit) begin
                case (off)
                    OFF_STATUS: if (i_wdata[STAT_OVF]) overflow <= 1'b0;
                    OFF_DIV:    div_reg <= i_wdata[15:0];
                    OFF_CTRL: begin
                        tx_en  <= i_wdata[CTRL_TX_EN];
                        irq_en <= i_wdata[CTRL_IRQ_EN];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_irq = irq_q;

    // read mux
    logic [31:0] status_word;

    always_comb begin
        status_word                                 = '0;
        status_word[STAT_BUSY]                      = busy;
        status_word[STAT_FULL]                      = fifo_full;
        status_word[STAT_EMPTY]                     = fifo_empty;
        status_word[STAT_OVF]                       = overflow;
        status_word[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        o_rdata = '0;
        if (rd_hit) begin
            case (off)
                OFF_STATUS: o_rdata = status_word;
                OFF_DIV:    o_rdata = {16'd0, div_reg};
                OFF_CTRL:   o_rdata = {30'd0, irq_en, tx_en};
                default:    o_rdata = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_addr[1:0], i_wdata[31:16]};

endmodule
